// File: rtl/rom_reader.sv
// rom_reader: sequential read initiator for a 1024 x 32 ROM core.
// On start it walks a contiguous (wrapping) address range. For each word it
// holds cs_o/adr_o for RD_LAT cycles, captures d_i, and offers the word on
// a valid/ready stream. done_o pulses once when the burst completes.
// Optional running checksum on chk_o is enabled by defining the macro
// ROM_READER_CHKSUM_EN; without it chk_o is a constant zero.

module rom_reader #(
    parameter int AW     = 10,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [AW-1:0] base_adr_i,
    input  logic [AW:0]   len_i,
    output logic [AW-1:0] adr_o,
    output logic          cs_o,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [DW-1:0] chk_o
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        HOLD,
        FIN
    } state_t;

    // The latency counter is 3 bits wide so RD_LAT up to 4 fits (0..3).
    localparam logic [2:0]    LAT_LAST = 3'(RD_LAT - 1);
    localparam logic [AW-1:0] ADR_ONE  = 1;
    localparam logic [AW:0]   REM_ONE  = 1;

    state_t        state;
    logic [AW:0]   remaining;
    logic [2:0]    lat_cnt;
    logic          handshake;

    assign handshake = valid_o & ready_i;

    // Burst sequencer: adr_o doubles as the current address register and
    // keeps its last value whenever cs_o is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            adr_o     <= '0;
            cs_o      <= 1'b0;
            data_o    <= '0;
            valid_o   <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            remaining <= '0;
            lat_cnt   <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        busy_o <= 1'b1;
                        if (len_i != '0) begin
                            adr_o     <= base_adr_i;
                            remaining <= len_i;
                            lat_cnt   <= '0;
                            cs_o      <= 1'b1;
                            state     <= RD;
                        end else begin
                            done_o <= 1'b1;
                            state  <= FIN;
                        end
                    end
                end
                RD: begin
                    if (lat_cnt == LAT_LAST) begin
                        data_o  <= d_i;
                        valid_o <= 1'b1;
                        cs_o    <= 1'b0;
                        state   <= HOLD;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                HOLD: begin
                    if (handshake) begin
                        valid_o   <= 1'b0;
                        remaining <= remaining - REM_ONE;
                        if (remaining == REM_ONE) begin
                            done_o <= 1'b1;
                            state  <= FIN;
                        end else begin
                            adr_o   <= adr_o + ADR_ONE;
                            cs_o    <= 1'b1;
                            lat_cnt <= '0;
                            state   <= RD;
                        end
                    end
                end
                FIN: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ROM_READER_CHKSUM_EN
    logic [DW-1:0] chk_q;

    // Running sum of every accepted word, cleared when a new burst is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_q <= '0;
        end else if (state == IDLE && start_i) begin
            chk_q <= '0;
        end else if (state == HOLD && handshake) begin
            chk_q <= chk_q + data_o;
        end
    end

    assign chk_o = chk_q;
`else
    assign chk_o = '0;
`endif

endmodule

// File: tb/tb_rom_reader.sv
// tb_rom_reader: directed bench for rom_reader with a data/address scoreboard.
// Instance dut uses RD_LAT=1; instance dut3 uses RD_LAT=3 for the checksum case.

module tb_rom_reader;

    logic        clk;
    logic        rst_n;
    logic        start1;
    logic        start3;
    logic [9:0]  base;
    logic [10:0] len;
    logic        ready;

    logic [9:0]  adr1;
    logic        cs1;
    logic [31:0] d1;
    logic [31:0] data1;
    logic        valid1;
    logic        busy1;
    logic        done1;
    logic [31:0] chk1;

    logic [9:0]  adr3;
    logic        cs3;
    logic [31:0] d3;
    logic [31:0] data3;
    logic        valid3;
    logic        busy3;
    logic        done3;
    logic [31:0] chk3;

    logic [31:0] rom [1024];

    logic [31:0] exp_data [$];
    logic [9:0]  exp_adr  [$];

    int checks;
    int errors;
    int done_cnt;
    int cs_run;
    logic cs_prev;

`ifdef ROM_READER_CHKSUM_EN
    localparam logic [31:0] EXP_CHK3 = 32'h0000_0002;
`else
    localparam logic [31:0] EXP_CHK3 = 32'h0000_0000;
`endif

    // ROM model: data only meaningful while selected, garbage otherwise.
    assign d1 = cs1 ? rom[adr1] : 32'hBADC_0DE5;
    assign d3 = cs3 ? rom[adr3] : 32'hBADC_0DE5;

    rom_reader #(.AW(10), .DW(32), .RD_LAT(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start1),
        .base_adr_i (base),
        .len_i      (len),
        .adr_o      (adr1),
        .cs_o       (cs1),
        .d_i        (d1),
        .data_o     (data1),
        .valid_o    (valid1),
        .ready_i    (ready),
        .busy_o     (busy1),
        .done_o     (done1),
        .chk_o      (chk1)
    );

    rom_reader #(.AW(10), .DW(32), .RD_LAT(3)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start3),
        .base_adr_i (base),
        .len_i      (len),
        .adr_o      (adr3),
        .cs_o       (cs3),
        .d_i        (d3),
        .data_o     (data3),
        .valid_o    (valid3),
        .ready_i    (ready),
        .busy_o     (busy3),
        .done_o     (done3),
        .chk_o      (chk3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string tag, logic [63:0] obs, logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_burst(logic [9:0] b, int n);
        logic [9:0] a;
        for (int i = 0; i < n; i++) begin
            a = b + 10'(i);
            exp_adr.push_back(a);
            exp_data.push_back(rom[a]);
        end
    endtask

    task automatic wait_done1(string tag);
        int i;
        i = 0;
        while (!done1 && i < 200) begin
            step(1);
            i++;
        end
        check(tag, done1, 1);
    endtask

    // Scoreboard monitor for dut: address order, cs length, no cs in HOLD, data order.
    always @(negedge clk) begin
        if (!rst_n) begin
            cs_prev = 1'b0;
            cs_run  = 0;
        end else begin
            if (cs1 && !cs_prev) begin
                check("cs_expected", exp_adr.size() > 0, 1);
                if (exp_adr.size() > 0) check("adr_seq", adr1, exp_adr.pop_front());
            end
            if (cs1) begin
                cs_run++;
            end else if (cs_prev) begin
                check("cs_len", cs_run, 1);
                cs_run = 0;
            end
            check("cs_in_hold", cs1 & valid1, 0);
            if (valid1 && ready) begin
                check("word_expected", exp_data.size() > 0, 1);
                if (exp_data.size() > 0) check("word_data", data1, exp_data.pop_front());
            end
            if (done1) done_cnt++;
            cs_prev = cs1;
        end
    end

    initial begin
        int d0;
        logic [31:0] held;
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        cs_run   = 0;
        cs_prev  = 1'b0;
        for (int i = 0; i < 1024; i++) rom[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_A5A5;
        rom[0] = 32'h0000_0001;
        rom[1] = 32'h0000_0002;
        rom[2] = 32'hFFFF_FFFF;
        rom[3] = 32'h1234_5678;
        rom[5] = 32'hDEAD_BEEF;

        rst_n  = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        base   = '0;
        len    = '0;
        ready  = 1'b1;
        step(2);

        // Reset state of both instances
        check("rst_adr", adr1, 0);
        check("rst_cs", cs1, 0);
        check("rst_data", data1, 0);
        check("rst_valid", valid1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_chk", chk1, 0);
        check("rst3_cs", cs3, 0);
        check("rst3_chk", chk3, 0);
        rst_n = 1'b1;
        step(1);

        // Single read, RD_LAT=1
        d0 = done_cnt;
        push_burst(10'd5, 1);
        start1 = 1'b1; base = 10'd5; len = 11'd1;
        step(1);
        start1 = 1'b0;
        check("single_cs", cs1, 1);
        check("single_adr", adr1, 5);
        check("single_busy", busy1, 1);
        check("single_valid_early", valid1, 0);
        step(1);
        check("single_valid", valid1, 1);
        check("single_data", data1, 32'hDEAD_BEEF);
        check("single_cs_off", cs1, 0);
        step(1);
        check("single_done", done1, 1);
        check("single_busy_fin", busy1, 1);
        step(1);
        check("single_done_off", done1, 0);
        check("single_busy_off", busy1, 0);
        check("single_adr_held", adr1, 5);
        check("single_done_cnt", done_cnt - d0, 1);

        // Burst with backpressure on the second word
        d0 = done_cnt;
        push_burst(10'd0, 4);
        start1 = 1'b1; base = 10'd0; len = 11'd4;
        step(1);
        start1 = 1'b0;
        step(2);
        ready = 1'b0;
        step(1);
        check("stall_valid", valid1, 1);
        held = data1;
        check("stall_word", held, rom[1]);
        step(1);
        check("stall_hold_data1", data1, held);
        check("stall_hold_valid1", valid1, 1);
        step(1);
        check("stall_hold_data2", data1, held);
        check("stall_cs", cs1, 0);
        ready = 1'b1;
        wait_done1("burst_done_timeout");
        step(1);
        check("burst_done_cnt", done_cnt - d0, 1);
        check("burst_all_words", exp_data.size(), 0);

        // Wrap-around across the top of the address space
        d0 = done_cnt;
        push_burst(10'd1022, 4);
        start1 = 1'b1; base = 10'd1022; len = 11'd4;
        step(1);
        start1 = 1'b0;
        wait_done1("wrap_done_timeout");
        step(1);
        check("wrap_all_words", exp_data.size(), 0);
        check("wrap_all_adrs", exp_adr.size(), 0);
        check("wrap_last_adr", adr1, 1);
        check("wrap_done_cnt", done_cnt - d0, 1);

        // Zero-length request
        start1 = 1'b1; base = 10'd9; len = 11'd0;
        step(1);
        start1 = 1'b0;
        check("len0_done", done1, 1);
        check("len0_cs", cs1, 0);
        step(1);
        check("len0_done_off", done1, 0);
        check("len0_busy_off", busy1, 0);

        // Start while busy is ignored; start in the FIN cycle is ignored
        d0 = done_cnt;
        push_burst(10'd10, 3);
        start1 = 1'b1; base = 10'd10; len = 11'd3;
        step(1);
        start1 = 1'b0;
        step(1);
        start1 = 1'b1; base = 10'd100; len = 11'd5;
        step(1);
        start1 = 1'b0;
        wait_done1("busy_done_timeout");
        start1 = 1'b1; base = 10'd50; len = 11'd2;
        step(1);
        start1 = 1'b0;
        check("fin_start_busy", busy1, 0);
        check("fin_start_cs", cs1, 0);
        step(3);
        check("busy_words", exp_data.size(), 0);
        check("busy_done_cnt", done_cnt - d0, 1);
        check("busy_idle", busy1, 0);

        // Reset during RD of word 3 of 8
        d0 = done_cnt;
        push_burst(10'd20, 8);
        start1 = 1'b1; base = 10'd20; len = 11'd8;
        step(1);
        start1 = 1'b0;
        step(4);
        check("midrst_cs", cs1, 1);
        check("midrst_adr", adr1, 22);
        rst_n = 1'b0;
        step(1);
        check("midrst_adr0", adr1, 0);
        check("midrst_cs0", cs1, 0);
        check("midrst_data0", data1, 0);
        check("midrst_valid0", valid1, 0);
        check("midrst_busy0", busy1, 0);
        check("midrst_done0", done1, 0);
        check("midrst_chk0", chk1, 0);
        rst_n = 1'b1;
        exp_data.delete();
        exp_adr.delete();
        step(2);
        check("midrst_no_done", done_cnt - d0, 0);
        push_burst(10'd7, 2);
        start1 = 1'b1; base = 10'd7; len = 11'd2;
        step(1);
        start1 = 1'b0;
        wait_done1("postrst_done_timeout");
        step(1);
        check("postrst_words", exp_data.size(), 0);
        check("postrst_done_cnt", done_cnt - d0, 1);

        // RD_LAT=3 instance with checksum
        start3 = 1'b1; base = 10'd0; len = 11'd3;
        step(1);
        start3 = 1'b0;
        for (int w = 0; w < 3; w++) begin
            for (int c = 0; c < 3; c++) begin
                check("lat3_cs", cs3, 1);
                check("lat3_adr", adr3, w);
                check("lat3_valid_low", valid3, 0);
                step(1);
            end
            check("lat3_cs_off", cs3, 0);
            check("lat3_valid", valid3, 1);
            check("lat3_data", data3, rom[w]);
            step(1);
        end
        check("lat3_done", done3, 1);
        check("lat3_chk", chk3, EXP_CHK3);
        step(1);
        check("lat3_done_off", done3, 0);
        check("lat3_chk_held", chk3, EXP_CHK3);
        check("lat3_busy_off", busy3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_reader.md
Name: rom_reader

Overview:
- Sequential read initiator for the 1024 x 32 ROM core (10-bit address, chip select, 32-bit data out).
- On a start command it walks a contiguous address range.
- For each word it drives address/chip-select toward the ROM, waits a programmable read latency, and captures the data.
- Each captured word is presented on a valid/ready output stream.
- Sits between the ROM's pad-side interface and any consumer: boot loader, table fetch or BIST.

Parameters:
- AW, 10, ROM address width.
- DW, 32, ROM data width.
- RD_LAT, 1, cycles cs_o/adr_o are held before d_i is sampled (legal 1..4).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start_i  input  1  one-cycle request to begin a burst; ignored while busy_o=1.
- base_adr_i  input  AW  first ROM address of the burst, sampled with start_i.
- len_i  input  AW+1  number of words to read (0..1024), sampled with start_i.
- adr_o  output  AW  address to ROM.
- cs_o  output  1  chip select to ROM, active high.
- d_i  input  DW  ROM data out.
- data_o  output  DW  captured word.
- valid_o  output  1  data_o holds an unconsumed word.
- ready_i  input  1  consumer accepts data_o when valid_o&ready_i.
- busy_o  output  1  burst in progress.
- done_o  output  1  one-cycle pulse at burst completion.
- chk_o  output  DW  running checksum (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - adr_o, cs_o, data_o, valid_o, busy_o, done_o and chk_o all 0.
  - Reset mid-burst aborts immediately; no done_o pulse is issued.
- States are IDLE, RD, HOLD and FIN.
- IDLE:
  - start_i=1 with len_i>0: latch cur_adr=base_adr_i and remaining=len_i, set busy_o=1, go to RD.
  - start_i=1 with len_i=0: go to FIN without asserting cs_o.
- RD:
  - cs_o=1 and adr_o=cur_adr for exactly RD_LAT consecutive cycles; an internal latency counter counts 0..RD_LAT-1.
  - On the edge ending the last RD cycle: data_o<=d_i, valid_o<=1, cs_o<=0, go to HOLD.
  - First valid_o therefore appears RD_LAT+1 cycles after the start_i cycle.
- HOLD:
  - cs_o=0; data_o and valid_o are held stable while ready_i=0.
  - On valid_o&ready_i: valid_o<=0 and remaining decrements.
  - If remaining was 1, go to FIN.
  - Otherwise cur_adr<=cur_adr+1 (modulo 2^AW, so 1023 wraps to 0) and go to RD next cycle.
  - Steady-state throughput is 1 word per RD_LAT+1 cycles with ready_i held high.
- FIN: done_o=1 for exactly one cycle, busy_o<=0, go to IDLE.
  - A start_i in the FIN cycle is ignored.
  - A new start_i is accepted from the following cycle.
- adr_o retains its last driven value while cs_o=0.
- d_i is sampled only at the final RD cycle; it is don't-care at all other times.
- len_i=1024 reads the full ROM once, including the wrap when base_adr_i≠0.
- busy_o is 1 from the cycle after start acceptance through the FIN cycle inclusive.

Optional Feature:
- Macro ROM_READER_CHKSUM_EN.
- When defined:
  - chk_o is cleared to 0 on start acceptance.
  - On every valid_o&ready_i handshake, chk_o<=chk_o+data_o (mod 2^DW).
  - The value is final and stable in the FIN cycle and is held until the next start is accepted.
- When undefined: chk_o is tied to 0 and no adder or register is synthesized.

Test Plan:
- Single read, RD_LAT=1: start with base=5, len=1, ROM[5]=0xDEADBEEF, ready_i=1.
  - Response: cs_o=1 for 1 cycle with adr_o=5, then valid_o=1 with data_o=0xDEADBEEF, then done_o pulse.
  - Total: 3 cycles from start to done.
- Burst with backpressure: base=0, len=4, ready_i low for 3 cycles on word 2.
  - Response: words ROM[0..3] delivered in order; data_o is stable during the stall; no cs_o while in HOLD; one done_o pulse.
- Wrap-around: base=1022, len=4.
  - Response: adr_o sequence is 1022, 1023, 0, 1 and 4 words are delivered.
- Edge cases:
  - len=0 → done_o pulses on the cycle after start, with cs_o never asserted.
  - start_i while busy_o=1 → ignored, and the current burst completes unchanged.
- Reset mid-burst (rst_n=0 during RD of word 3 of 8):
  - Response: next cycle all outputs are 0 and state is IDLE, with no done_o.
  - A new start after reset works normally.
- RD_LAT=3 with ROM_READER_CHKSUM_EN defined: base=0, len=3, ROM[0..2]=1, 2, 0xFFFFFFFF.
  - Response: cs_o is held for 3 cycles per word.
  - chk_o=0x00000002 at done_o.
